// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pkg
// Brief    : Shared types and the magnitude-compare helper for the RGB
//            comparison indicator.
// Revision : 1.0 - initial release
// ============================================================================
package rgb_pkg;

    typedef enum logic [1:0] {
        CMP_NONE = 2'b00,
        CMP_LT   = 2'b01,
        CMP_EQ   = 2'b10,
        CMP_GT   = 2'b11
    } cmp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // Operands are zero-extended to this width by the caller; WIDTH up to 64.
    localparam int CMP_MAX_W = 64;

    function automatic cmp_e cmp_f(input logic [CMP_MAX_W-1:0] a,
                                   input logic [CMP_MAX_W-1:0] b);
        if (a > b) begin
            return CMP_GT;
        end else if (a == b) begin
            return CMP_EQ;
        end else begin
            return CMP_LT;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_gen
// Brief    : Free-running PWM counter with a duty compare; one instance is
//            shared by all LED channels.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Full-scale duty leaves exactly one dark cycle per period.
    assign pwm_out = (r_cnt < duty);

endmodule
`default_nettype wire

// File: rtl/rgb_cmp_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgb_cmp_led_ctrl
// Brief    : Latches two operands on load and shows their relation on an RGB
//            LED with PWM brightness, optional blink and a display hold time.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_cmp_led_ctrl
    import rgb_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          PWM_BITS    = 8,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned BLINK_DIV   = 12_500_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_en,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic [1:0]          cmp,
    output logic                busy
);

    localparam int HOLD_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 2)   ? $clog2(BLINK_DIV)   : 1;

    localparam logic [HOLD_W-1:0]  c_hold_last  =
        HOLD_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_DIV - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    cmp_e                r_cmp;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_blink_en;
    logic                r_phase;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;

    logic                w_hold_done;
    logic                w_pwm_on;
    logic                w_lit;
    logic [CMP_MAX_W-1:0] w_a_ext;
    logic [CMP_MAX_W-1:0] w_b_ext;

    assign w_a_ext     = CMP_MAX_W'(a);
    assign w_b_ext     = CMP_MAX_W'(b);
    assign w_hold_done = (HOLD_CYCLES != 0) && (r_hold_cnt == c_hold_last);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // A reload in the expiry cycle keeps the display alive.
                if (load) begin
                    w_state_nxt = ST_SHOW;
                end else if (w_hold_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- capture, hold and blink ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp       <= CMP_NONE;
            r_duty      <= '0;
            r_blink_en  <= 1'b0;
            r_phase     <= 1'b0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
        end else if (load) begin
            r_cmp       <= cmp_f(w_a_ext, w_b_ext);
            r_duty      <= duty;
            r_blink_en  <= blink_en;
            r_phase     <= 1'b1;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
        end else if (r_state == ST_SHOW) begin
            if (HOLD_CYCLES != 0) begin
                if (w_hold_done) begin
                    r_hold_cnt <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    rgb_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .duty    (r_duty),
        .pwm_out (w_pwm_on)
    );

    // ---------------- output decode (registered sources only) ----------------
    assign w_lit = (r_state == ST_SHOW) && w_pwm_on && (!r_blink_en || r_phase);

    assign red   = w_lit && (r_cmp == CMP_GT);
    assign green = w_lit && (r_cmp == CMP_EQ);
    assign blue  = w_lit && (r_cmp == CMP_LT);
    assign cmp   = r_cmp;
    assign busy  = (r_state == ST_SHOW);

endmodule
`default_nettype wire

// File: tb/tb_rgb_cmp_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_cmp_led_ctrl
// Brief    : Scoreboard bench for rgb_cmp_led_ctrl (WIDTH=4, PWM_BITS=2,
//            HOLD_CYCLES=16, BLINK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_cmp_led_ctrl;

    localparam int WIDTH       = 4;
    localparam int PWM_BITS    = 2;
    localparam int HOLD_CYCLES = 16;
    localparam int BLINK_DIV   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                load;
    logic [PWM_BITS-1:0] duty;
    logic                blink_en;
    logic                red;
    logic                green;
    logic                blue;
    logic [1:0]          cmp;
    logic                busy;

    // {cmp[1:0], busy, red, green, blue}
    logic [5:0]          obs;
    logic [5:0]          exp_v;
    logic [5:0]          sb_q[$];
    int                  vectors    = 0;
    int                  miscompares = 0;

    assign obs = {cmp, busy, red, green, blue};

    always #5 clk = ~clk;

    rgb_cmp_led_ctrl #(
        .WIDTH       (WIDTH),
        .PWM_BITS    (PWM_BITS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .load     (load),
        .duty     (duty),
        .blink_en (blink_en),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .cmp      (cmp),
        .busy     (busy)
    );

    function automatic logic [1:0] ref_cmp(input int x, input int y);
        if (x > y)       return 2'b11;
        else if (x == y) return 2'b10;
        else             return 2'b01;
    endfunction

    // Expected outputs in the k-th cycle (1-based) after a load edge.
    function automatic logic [5:0] exp_show(input logic [1:0] c, input int d,
                                            input logic bl, input int k);
        int   pwm;
        logic ph;
        logic lit;
        pwm = (k - 1) % (1 << PWM_BITS);
        ph  = (((k - 1) / BLINK_DIV) % 2) == 0;
        lit = (pwm < d) && (!bl || ph);
        return {c, 1'b1, lit && (c == 2'b11), lit && (c == 2'b10), lit && (c == 2'b01)};
    endfunction

    function automatic logic [5:0] exp_idle(input logic [1:0] c);
        return {c, 4'b0000};
    endfunction

    task automatic apply_load(input int pa, input int pb, input int pd, input logic pbl);
        a        = WIDTH'(pa);
        b        = WIDTH'(pb);
        duty     = PWM_BITS'(pd);
        blink_en = pbl;
        load     = 1'b1;
        @(posedge clk); #1;
        load     = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        duty     = PWM_BITS'($urandom);
        blink_en = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; a = '0; b = '0; duty = '0; blink_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(6'b0);
        sb_q.push_back(6'b0);
        exp_v = sb_q.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset: got %b expected %b", obs, exp_v);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_gt_pwm();
        apply_load(9, 3, 3, 1'b0);
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b11, 3, 1'b0, k));
        repeat (2) sb_q.push_back(exp_idle(2'b11));
        for (int i = 1; i <= HOLD_CYCLES + 2; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL gt_pwm cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_eq_dark();
        apply_load(5, 5, 0, 1'b0);
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b10, 0, 1'b0, k));
        sb_q.push_back(exp_idle(2'b10));
        for (int i = 1; i <= HOLD_CYCLES + 1; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL eq_dark cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lt_blink();
        apply_load(2, 14, 3, 1'b1);
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b01, 3, 1'b1, k));
        sb_q.push_back(exp_idle(2'b01));
        for (int i = 1; i <= HOLD_CYCLES + 1; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lt_blink cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        apply_load(9, 3, 3, 1'b0);
        for (int k = 1; k <= 9; k++) sb_q.push_back(exp_show(2'b11, 3, 1'b0, k));
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b01, 3, 1'b0, k));
        sb_q.push_back(exp_idle(2'b01));
        for (int i = 1; i <= 26; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (i == 9) begin
                a = 4'd1; b = 4'd8; duty = 2'd3; blink_en = 1'b0; load = 1'b1;
            end
            @(posedge clk); #1;
            load = 1'b0;
        end
    endtask

    task automatic test_load_at_expiry();
        apply_load(9, 3, 3, 1'b0);
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b11, 3, 1'b0, k));
        for (int k = 1; k <= HOLD_CYCLES; k++) sb_q.push_back(exp_show(2'b10, 2, 1'b0, k));
        sb_q.push_back(exp_idle(2'b10));
        for (int i = 1; i <= 2 * HOLD_CYCLES + 1; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL load_at_expiry cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (i == HOLD_CYCLES) begin
                a = 4'd6; b = 4'd6; duty = 2'd2; blink_en = 1'b0; load = 1'b1;
            end
            @(posedge clk); #1;
            load = 1'b0;
        end
    endtask

    task automatic test_reset_mid_show();
        apply_load(9, 3, 3, 1'b0);
        for (int k = 1; k <= 5; k++) sb_q.push_back(exp_show(2'b11, 3, 1'b0, k));
        repeat (3) sb_q.push_back(6'b0);
        for (int i = 1; i <= 8; i++) begin
            exp_v = sb_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_show cyc%0d: got %b expected %b", i, obs, exp_v);
            end
            if (i == 5) begin
                rst = 1'b1; a = 4'd1; b = 4'd1; duty = 2'd3; load = 1'b1;
            end
            if (i == 7) begin
                rst = 1'b0; load = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int          ra, rb, rd;
        logic        rbl;
        logic [1:0]  rc;
        for (int n = 0; n < 200; n++) begin
            ra  = int'($urandom_range(0, (1 << WIDTH) - 1));
            rb  = int'($urandom_range(0, (1 << WIDTH) - 1));
            rd  = int'($urandom_range(0, (1 << PWM_BITS) - 1));
            rbl = 1'($urandom);
            rc  = ref_cmp(ra, rb);
            for (int k = 1; k <= 3; k++) sb_q.push_back(exp_show(rc, rd, rbl, k));
            apply_load(ra, rb, rd, rbl);
            for (int k = 1; k <= 3; k++) begin
                exp_v = sb_q.pop_front();
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL random a=%0d b=%0d cyc%0d: got %b expected %b",
                             ra, rb, k, obs, exp_v);
                end
                vectors++;
                if ($countones({red, green, blue}) > 1) begin
                    miscompares++;
                    $display("FAIL onehot: got rgb=%b expected at most one set", {red, green, blue});
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gt_pwm();
        test_eq_dark();
        test_lt_blink();
        test_back_to_back();
        test_load_at_expiry();
        test_reset_mid_show();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
